// File: rtl/result_reader.sv
// result_reader
//   Drains rows 0..num_rows-1 of a result memory into a downstream output
//   FIFO, three cycles per row (READ, CAPTURE, PUSH), stalling in PUSH while
//   the FIFO is full.
//
//   Optional feature: define RESULT_READER_CLEAR_EN to add a clear-write
//   port that zeroes each row in the same cycle it is pushed, so the memory
//   is ready for the next accumulation pass.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   start, num_rows    drain request and row count (sampled when accepted)
//   rd_addr, rd_en     result-memory read port
//   rd_data            read data, valid one cycle after rd_en
//   out_full           downstream FIFO full
//   out_wr_en          FIFO push strobe
//   out_row, out_data  row index and word of the push
//   busy, done         activity flag, one-cycle completion pulse
//   clr_addr, clr_data, clr_en   clear-write port (RESULT_READER_CLEAR_EN only)
//
// state   | meaning
// IDLE    | waiting for start
// READ    | rd_en asserted for row idx
// CAPTURE | rd_data valid, latched into the holding register
// PUSH    | push holding register when the FIFO has room
// DONE    | one-cycle done pulse
module result_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_rows,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              out_full,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_row,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
`ifdef RESULT_READER_CLEAR_EN
  ,
  output logic [ADDR_W-1:0] clr_addr,
  output logic [DATA_W-1:0] clr_data,
  output logic              clr_en
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_PUSH,
    S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] count;
  logic [DATA_W-1:0] hold_data;
  logic [ADDR_W-1:0] hold_row;
  logic [DATA_W-1:0] last_data;
  logic [ADDR_W-1:0] last_row;

  // The push must react to out_full in the same cycle, so the strobe is
  // decoded from the state rather than registered.
  assign out_wr_en = (state == S_PUSH) && !out_full;

  // The holding register is loaded in CAPTURE, before the push; the output
  // shows it only while pushing so that out_row/out_data otherwise keep the
  // last pushed values.
  assign out_data = out_wr_en ? hold_data : last_data;
  assign out_row  = out_wr_en ? hold_row  : last_row;

`ifdef RESULT_READER_CLEAR_EN
  assign clr_en   = out_wr_en;
  assign clr_addr = out_row;
  assign clr_data = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      count     <= '0;
      hold_data <= '0;
      hold_row  <= '0;
      last_data <= '0;
      last_row  <= '0;
      rd_addr   <= '0;
      rd_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (num_rows != '0) begin
              state   <= S_READ;
              idx     <= '0;
              count   <= num_rows;
              rd_en   <= 1'b1;
              rd_addr <= '0;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_READ: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          hold_data <= rd_data;
          hold_row  <= idx;
          state     <= S_PUSH;
        end
        S_PUSH: begin
          if (!out_full) begin
            last_data <= hold_data;
            last_row  <= hold_row;
            // count >= 1 here, so count-1 never underflows and idx stops
            // at count-1 without wrapping.
            if (idx == count - ADDR_W'(1)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              idx     <= idx + ADDR_W'(1);
              rd_addr <= idx + ADDR_W'(1);
              rd_en   <= 1'b1;
              state   <= S_READ;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/result_reader.md
RESULT_READER -- requirements
Module: result_reader

Interface
REQ-001 Parameter ADDR_W, default 8, width of the result-memory row address.
REQ-002 Parameter DATA_W, default 16, width of one accumulated result word.
REQ-003 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 start  input  1  one-cycle request to drain rows 0..num_rows-1; honoured only in IDLE.
REQ-006 num_rows  input  ADDR_W  row count, sampled on the accepted start; 0 means no rows.
REQ-007 rd_addr  output  ADDR_W  result-memory read address.
REQ-008 rd_en  output  1  result-memory read strobe.
REQ-009 rd_data  input  DATA_W  read data, valid exactly one cycle after rd_en.
REQ-010 out_full  input  1  downstream output FIFO full.
REQ-011 out_wr_en  output  1  push strobe into the output FIFO.
REQ-012 out_row  output  ADDR_W  row index of the pushed word.
REQ-013 out_data  output  DATA_W  pushed result word.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse when the drain completes.
REQ-016 clr_addr, clr_data, clr_en  outputs  ADDR_W, DATA_W, 1  result-memory clear-write port; present only with the clear feature (see Configuration).

Function
REQ-017 The FSM SHALL have states IDLE, READ, CAPTURE, PUSH, DONE.
- IDLE: start=1 and num_rows!=0 -> READ, idx<=0, count<=num_rows.
- IDLE: start=1 and num_rows==0 -> DONE.
REQ-018 READ: rd_en=1 and rd_addr=idx for exactly one cycle; next state CAPTURE.
REQ-019 CAPTURE: latch rd_data into a holding register and idx into out_row; next state PUSH.
REQ-020 PUSH with out_full=1: hold state; out_wr_en=0; holding register unchanged.
REQ-021 PUSH with out_full=0: out_wr_en=1 for one cycle with out_data/out_row from the holding register.
- idx==count-1 -> DONE.
- Otherwise idx<=idx+1 -> READ.
REQ-022 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-023 Throughput SHALL be 3 cycles per row when out_full stays low.
- Latency from accepted start to the first out_wr_en is 3 cycles.
REQ-024 start SHALL be ignored while busy=1; num_rows changes after acceptance SHALL have no effect.
REQ-025 num_rows=2^ADDR_W-1 SHALL drain rows 0..2^ADDR_W-2.
- idx SHALL never wrap within a drain.
REQ-026 rd_en and out_wr_en SHALL never be asserted in the same cycle.
REQ-027 out_data and out_row SHALL hold their last values when out_wr_en=0.

Reset
REQ-028 While Reset=1, the FSM SHALL be in IDLE.
REQ-029 While Reset=1, idx, count, the holding register, rd_addr, out_row and out_data SHALL be 0.
REQ-030 While Reset=1, rd_en, out_wr_en, clr_en, busy and done SHALL be 0.
REQ-031 Reset asserted mid-drain SHALL abort the drain with no further push and no done pulse.
REQ-032 After Reset deasserts, the block SHALL wait for a new start.

Configuration
REQ-033 Macro RESULT_READER_CLEAR_EN SHALL select the clear-on-read feature.
REQ-034 With RESULT_READER_CLEAR_EN defined, the clear-write port SHALL exist.
- clr_en=1, clr_addr=out_row and clr_data=0 in the same cycle as each out_wr_en.
- Each drained row is zeroed for the next accumulation pass.
REQ-035 Without RESULT_READER_CLEAR_EN, the clr_* ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-036 Bench SHALL cover: Reset=1 for 10 cycles then release -> all outputs 0, busy=0.
REQ-037 Bench SHALL cover: memory rows 0..3 = 5,6,7,8, start with num_rows=4, out_full=0 -> four pushes (row,data)=(0,5),(1,6),(2,7),(3,8), 3 cycles apart, first push 3 cycles after start, then done pulse.
REQ-038 Bench SHALL cover: same drain with out_full=1 for 5 cycles during row-1 PUSH -> row-1 push delayed 5 cycles, data intact, no duplicate push.
REQ-039 Bench SHALL cover: start with num_rows=0 -> done pulse on the next cycle; no rd_en, no out_wr_en.
REQ-040 Bench SHALL cover: Reset pulsed after the second push of a 4-row drain -> no further pushes, no done pulse; a new start then drains correctly from row 0.
REQ-041 Bench SHALL cover: with RESULT_READER_CLEAR_EN defined, a 4-row drain -> clr_en=1 with clr_data=0 at addresses 0..3, coincident with each push; a second drain then returns all zeros.
